// File: rtl/modulo_unit_pkg.sv
// Shared definitions for the modulo path: default width, counter width and FSM states.
package modulo_unit_pkg;

  localparam int MOD_WIDTH = 16;
  localparam int MOD_CNT_W = $clog2(MOD_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mod_state_t;

endpackage

// File: rtl/modulo_unit_if.sv
// Request/result bundle between the datapath controller (master) and the modulo unit (slave).
interface modulo_unit_if
  import modulo_unit_pkg::*;
#(
  parameter int WIDTH = MOD_WIDTH
);

  logic             modulo_start_i;
  logic [WIDTH-1:0] op_a_i;
  logic [WIDTH-1:0] op_b_i;
  logic [WIDTH-1:0] res_o;
  logic             modulo_ready_o;
  logic             busy_o;
  logic             div_by_zero_o;

  modport master (
    output modulo_start_i, op_a_i, op_b_i,
    input  res_o, modulo_ready_o, busy_o, div_by_zero_o
  );

  modport slave (
    input  modulo_start_i, op_a_i, op_b_i,
    output res_o, modulo_ready_o, busy_o, div_by_zero_o
  );

endinterface

// File: rtl/modulo_unit_step.sv
// One restoring shift-subtract iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor if it fits.
module modulo_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   r_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   r_o
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] b_ext;
  // The remainder entering a step is always below b, so its top bit is zero
  // and only the low WIDTH bits take part in the shift.
  logic           unused_r_msb;

  assign unused_r_msb = r_i[WIDTH];
  assign t            = {r_i[WIDTH-1:0], q_msb_i};
  assign b_ext        = {1'b0, b_i};

  // Unsigned WIDTH+1 compare keeps the shifted-out bit, so no overflow is possible.
  always_comb begin
    r_o = t;
    if (t >= b_ext) begin
      r_o = t - b_ext;
    end
  end

endmodule

// File: rtl/modulo_unit.sv
// Sequential unsigned a mod b, one quotient bit per clock, fixed WIDTH-cycle latency.
//
// state | meaning
// IDLE  | waiting for a start
// RUN   | iterating, one shift-subtract per cycle
// DONE  | result just published, ready pulse high
module modulo_unit
  import modulo_unit_pkg::*;
#(
  parameter int WIDTH = MOD_WIDTH
) (
  input  logic          clk,
  input  logic          rst_i,
  modulo_unit_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mod_state_t       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             ready_q, ready_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   r_step;

  modulo_step #(.WIDTH(WIDTH)) u_step (
    .r_i     (r_q),
    .q_msb_i (q_q[WIDTH-1]),
    .b_i     (b_q),
    .r_o     (r_step)
  );

  // Next-state and datapath updates; a start is honoured only outside RUN.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    ready_d = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.modulo_start_i) begin
          if (bus.op_b_i == '0) begin
            // Divide by zero completes immediately with the dividend as remainder.
            state_d = DONE;
            res_d   = bus.op_a_i;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            q_d     = bus.op_a_i;
            r_d     = '0;
            b_d     = bus.op_b_i;
            cnt_d   = '0;
          end
        end
      end
      RUN: begin
        q_d   = q_q << 1;
        r_d   = r_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          res_d   = r_step[WIDTH-1:0];
          dbz_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == DONE);
  end

  // State and datapath registers with synchronous reset; reset aborts any RUN silently.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      ready_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      ready_q <= ready_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.res_o          = res_q;
  assign bus.modulo_ready_o = ready_q;
  assign bus.busy_o         = (state_q == RUN);
  assign bus.div_by_zero_o  = dbz_q;

endmodule
